// File: rtl/tile_accum_pkg.sv
// Shared types and helpers for the tile accumulation engine.
package tile_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        MODE_SUM = 1'b0,
        MODE_MAX = 1'b1
    } mode_e;

    // Width needed to hold a tile count from 0 up to max_tiles inclusive.
    function automatic int cnt_width(input int max_tiles);
        return $clog2(max_tiles + 32'sd1);
    endfunction

    localparam int DEF_MAX_INPUT_TILES = 4;
    localparam int DEF_CNT_W           = cnt_width(DEF_MAX_INPUT_TILES);

    // Signed add of two sign-extended operands, clamped to the range of an
    // acc_w-bit signed number. The caller truncates the result to acc_w bits.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int acc_w);
        logic signed [64:0] sum_s;
        logic signed [64:0] hi_s;
        logic signed [64:0] lo_s;
        logic signed [63:0] res_s;
        sum_s = 65'(a) + 65'(b);
        hi_s  = (65'sd1 <<< (acc_w - 32'sd1)) - 65'sd1;
        lo_s  = -hi_s - 65'sd1;
        if (sum_s > hi_s) begin
            res_s = hi_s[63:0];
        end else if (sum_s < lo_s) begin
            res_s = lo_s[63:0];
        end else begin
            res_s = sum_s[63:0];
        end
        return res_s;
    endfunction

endpackage

// File: rtl/tile_accum_engine_tile_queue.sv
// Tile FIFO: first-word-fall-through read, push ignored when full,
// pop ignored when empty, flush empties the queue and wins over push/pop.
module tile_queue
    import tile_accum_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 256,
    parameter int CNT_W  = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == '0);
    assign count     = count_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign push_ok_s = push & ~full & ~flush;
    assign pop_ok_s  = pop & ~empty & ~flush;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Tile storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/tile_accum_engine.sv
// Buffers activation tiles, then reduces them lane-wise by saturating sum
// or signed max and holds the result until the consumer acknowledges it.
module tile_accum_engine
    import tile_accum_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int LANES           = 16,
    parameter int MAX_INPUT_TILES = 4,
    parameter int ACC_WIDTH       = 24,
    parameter int CNT_W           = cnt_width(MAX_INPUT_TILES)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             act_load,
    input  logic [CNT_W-1:0]                 num_input_tiles,
    input  logic                             mode,
    input  logic [LANES-1:0][WIDTH-1:0]      activation_input,
    input  logic                             result_ack,
    output logic                             ready,
    output logic                             busy,
    output logic [LANES-1:0][ACC_WIDTH-1:0]  accum_output,
    output logic [CNT_W-1:0]                 tiles_used,
    output logic                             overflow,
    output logic                             count_mismatch
);

    state_e                         state_r;
    mode_e                          md_r;
    logic [CNT_W-1:0]               tgt_r;
    logic [CNT_W-1:0]               loaded_r;
    logic [CNT_W-1:0]               pops_r;
    logic [CNT_W-1:0]               tiles_used_r;
    logic [CNT_W-1:0]               limit_s;
    logic [CNT_W-1:0]               q_count_s;
    logic                           ready_r;
    logic                           busy_r;
    logic                           overflow_r;
    logic                           mismatch_r;
    logic                           accum_last_s;
    logic                           q_push_s;
    logic                           q_pop_s;
    logic                           q_flush_s;
    logic                           q_full_s;
    logic                           q_empty_s;
    logic [LANES-1:0][WIDTH-1:0]    q_rdata_s;
    logic [LANES-1:0][ACC_WIDTH-1:0] acc_r;
    logic [LANES-1:0][ACC_WIDTH-1:0] acc_nxt_s;

    tile_queue #(
        .DEPTH  (MAX_INPUT_TILES),
        .DATA_W (LANES * WIDTH),
        .CNT_W  (CNT_W)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (q_push_s),
        .pop   (q_pop_s),
        .flush (q_flush_s),
        .wdata (activation_input),
        .rdata (q_rdata_s),
        .full  (q_full_s),
        .empty (q_empty_s),
        .count (q_count_s)
    );

    // Pop limit is the smaller of the requested and the actually loaded count;
    // the final ACCUM cycle is the last pop, or the only cycle when nothing pops.
    always_comb begin
        if (tgt_r < loaded_r) begin
            limit_s = tgt_r;
        end else begin
            limit_s = loaded_r;
        end
        if (state_r == ACCUM) begin
            accum_last_s = (limit_s == '0) || ((pops_r + CNT_W'(1'b1)) == limit_s);
        end else begin
            accum_last_s = 1'b0;
        end
    end

    // Queue control derived from the current state.
    always_comb begin
        q_push_s  = 1'b0;
        q_pop_s   = 1'b0;
        q_flush_s = 1'b0;
        case (state_r)
            IDLE:  q_push_s = act_load;
            LOAD:  q_push_s = act_load & ~q_full_s;
            ACCUM: begin
                q_pop_s   = (pops_r < limit_s) & ~q_empty_s;
                q_flush_s = accum_last_s;
            end
            DONE:    q_flush_s = result_ack;
            default: q_flush_s = 1'b0;
        endcase
    end

    // Lane-wise reduction of the queue head into the accumulator.
    always_comb begin
        logic signed [ACC_WIDTH-1:0] word_v;
        logic signed [ACC_WIDTH-1:0] acc_v;
        word_v    = '0;
        acc_v     = '0;
        acc_nxt_s = acc_r;
        for (int i = 0; i < LANES; i++) begin
            word_v = ACC_WIDTH'($signed(q_rdata_s[i]));
            acc_v  = $signed(acc_r[i]);
            if (pops_r == '0) begin
                acc_nxt_s[i] = word_v;
            end else if (md_r == MODE_MAX) begin
                acc_nxt_s[i] = (word_v > acc_v) ? word_v : acc_v;
            end else begin
                acc_nxt_s[i] = ACC_WIDTH'(sat_add(64'(word_v), 64'(acc_v), ACC_WIDTH));
            end
        end
    end

    // Control FSM with registered outputs and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            md_r         <= MODE_SUM;
            tgt_r        <= '0;
            loaded_r     <= '0;
            pops_r       <= '0;
            tiles_used_r <= '0;
            acc_r        <= '0;
            ready_r      <= 1'b0;
            busy_r       <= 1'b0;
            overflow_r   <= 1'b0;
            mismatch_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (act_load) begin
                        tgt_r      <= num_input_tiles;
                        md_r       <= mode_e'(mode);
                        overflow_r <= 1'b0;
                        mismatch_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= LOAD;
                    end
                end
                LOAD: begin
                    if (act_load) begin
                        if (q_full_s) begin
                            overflow_r <= 1'b1;
                        end
                    end else begin
                        loaded_r <= q_count_s;
                        pops_r   <= '0;
                        if (q_count_s != tgt_r) begin
                            mismatch_r <= 1'b1;
                        end
                        state_r <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (q_pop_s) begin
                        acc_r  <= acc_nxt_s;
                        pops_r <= pops_r + CNT_W'(1'b1);
                    end
                    if (accum_last_s) begin
                        if (limit_s == '0) begin
                            acc_r <= '0;
                        end
                        tiles_used_r <= limit_s;
                        ready_r      <= 1'b1;
                        state_r      <= DONE;
                    end
                end
                DONE: begin
                    if (result_ack) begin
                        acc_r        <= '0;
                        tiles_used_r <= '0;
                        loaded_r     <= '0;
                        pops_r       <= '0;
                        ready_r      <= 1'b0;
                        busy_r       <= 1'b0;
                        state_r      <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ready          = ready_r;
    assign busy           = busy_r;
    assign accum_output   = acc_r;
    assign tiles_used     = tiles_used_r;
    assign overflow       = overflow_r;
    assign count_mismatch = mismatch_r;

endmodule

// File: tb/tb_tile_accum_engine.sv
// Directed testbench for tile_accum_engine: a default-width instance and a
// 16-bit accumulator instance share all stimulus.
module tb_tile_accum_engine;

    localparam int W  = 16;
    localparam int LN = 16;
    localparam int MT = 4;
    localparam int CW = 3;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   act_load;
    logic [CW-1:0]          num_input_tiles;
    logic                   mode;
    logic [LN-1:0][W-1:0]   activation_input;
    logic                   result_ack;

    logic                   ready, busy, overflow, count_mismatch;
    logic [LN-1:0][23:0]    accum_output;
    logic [CW-1:0]          tiles_used;

    logic                   ready_s, busy_s, overflow_s, count_mismatch_s;
    logic [LN-1:0][15:0]    accum_output_s;
    logic [CW-1:0]          tiles_used_s;

    logic [LN-1:0][W-1:0]   tiles [8];
    int                     total = 0;
    int                     bad   = 0;

    tile_accum_engine #(.WIDTH(W), .LANES(LN), .MAX_INPUT_TILES(MT), .ACC_WIDTH(24)) dut (
        .clk(clk), .reset(reset), .act_load(act_load), .num_input_tiles(num_input_tiles),
        .mode(mode), .activation_input(activation_input), .result_ack(result_ack),
        .ready(ready), .busy(busy), .accum_output(accum_output), .tiles_used(tiles_used),
        .overflow(overflow), .count_mismatch(count_mismatch)
    );

    tile_accum_engine #(.WIDTH(W), .LANES(LN), .MAX_INPUT_TILES(MT), .ACC_WIDTH(16)) dut_s (
        .clk(clk), .reset(reset), .act_load(act_load), .num_input_tiles(num_input_tiles),
        .mode(mode), .activation_input(activation_input), .result_ack(result_ack),
        .ready(ready_s), .busy(busy_s), .accum_output(accum_output_s), .tiles_used(tiles_used_s),
        .overflow(overflow_s), .count_mismatch(count_mismatch_s)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint lane(input int i);
        return longint'($signed(accum_output[i]));
    endfunction

    function automatic longint lane_s(input int i);
        return longint'($signed(accum_output_s[i]));
    endfunction

    task automatic fill(input int k, input int v);
        for (int l = 0; l < LN; l++) tiles[k][l] = W'(v);
    endtask

    // Load n tiles, drop act_load, and measure cycles from L until ready.
    task automatic run_job(input string tag, input int n, input logic [CW-1:0] tgt,
                           input logic md, input int exp_lat);
        int lat;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            act_load         = 1'b1;
            activation_input = tiles[k];
            num_input_tiles  = tgt;
            mode             = md;
        end
        @(negedge clk);
        act_load = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ready && lat < 16);
        check_eq({tag, "_latency"}, lat, exp_lat);
    endtask

    task automatic ack(input string tag);
        @(negedge clk);
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        check_eq({tag, "_ack_ready"}, ready, 0);
        check_eq({tag, "_ack_busy"}, busy, 0);
        check_eq({tag, "_ack_lane0"}, lane(0), 0);
        check_eq({tag, "_ack_used"}, tiles_used, 0);
    endtask

    initial begin
        reset = 1'b1; act_load = 1'b0; num_input_tiles = '0; mode = 1'b0;
        activation_input = '0; result_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", ready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_lane0", lane(0), 0);
        check_eq("rst_lane15", lane(15), 0);
        check_eq("rst_used", tiles_used, 0);
        check_eq("rst_ovf", overflow, 0);
        check_eq("rst_mism", count_mismatch, 0);
        reset = 1'b0;

        // SUM of 1+2+3 over three tiles
        fill(0, 1); fill(1, 2); fill(2, 3);
        run_job("sum3", 3, 3'd3, 1'b0, 4);
        check_eq("sum3_lane0", lane(0), 6);
        check_eq("sum3_lane15", lane(15), 6);
        check_eq("sum3_used", tiles_used, 3);
        check_eq("sum3_busy", busy, 1);
        check_eq("sum3_ovf", overflow, 0);
        check_eq("sum3_mism", count_mismatch, 0);
        @(negedge clk);
        check_eq("sum3_hold_ready", ready, 1);
        check_eq("sum3_hold_lane7", lane(7), 6);
        ack("sum3");

        // MAX over signed values, lane0 and negated other lanes
        for (int k = 0; k < 4; k++) fill(k, 0);
        tiles[0][0] = W'(-5); tiles[1][0] = W'(7); tiles[2][0] = W'(-9); tiles[3][0] = W'(2);
        for (int l = 1; l < LN; l++) begin
            tiles[0][l] = W'(5); tiles[1][l] = W'(-7); tiles[2][l] = W'(9); tiles[3][l] = W'(-2);
        end
        run_job("max4", 4, 3'd4, 1'b1, 5);
        check_eq("max4_lane0", lane(0), 7);
        check_eq("max4_lane1", lane(1), 9);
        check_eq("max4_lane15", lane(15), 9);
        check_eq("max4_used", tiles_used, 4);
        ack("max4");

        // Saturation: 16-bit accumulator clamps, 24-bit accumulator does not
        for (int k = 0; k < 4; k++) fill(k, 32'h7FFF);
        run_job("satp", 4, 3'd4, 1'b0, 5);
        check_eq("satp_s_lane0", lane_s(0), 32767);
        check_eq("satp_s_lane15", lane_s(15), 32767);
        check_eq("satp_lane0", lane(0), 131068);
        ack("satp");
        for (int k = 0; k < 4; k++) fill(k, 32'h8000);
        run_job("satn", 4, 3'd4, 1'b0, 5);
        check_eq("satn_s_lane0", lane_s(0), -32768);
        check_eq("satn_lane3", lane(3), -131072);
        ack("satn");

        // Overflow: six tiles into a depth-four queue
        for (int k = 0; k < 6; k++) fill(k, k + 1);
        run_job("ovf", 6, 3'd4, 1'b0, 5);
        check_eq("ovf_flag", overflow, 1);
        check_eq("ovf_mism", count_mismatch, 0);
        check_eq("ovf_lane0", lane(0), 10);
        check_eq("ovf_used", tiles_used, 4);
        ack("ovf");
        check_eq("ovf_sticky", overflow, 1);

        // Fewer tiles loaded than requested
        fill(0, 10); fill(1, 20);
        run_job("mism", 2, 3'd3, 1'b0, 3);
        check_eq("mism_flag", count_mismatch, 1);
        check_eq("mism_ovf_cleared", overflow, 0);
        check_eq("mism_used", tiles_used, 2);
        check_eq("mism_lane0", lane(0), 30);
        ack("mism");

        // Zero target
        fill(0, 5);
        run_job("zero", 1, 3'd0, 1'b0, 2);
        check_eq("zero_lane0", lane(0), 0);
        check_eq("zero_lane9", lane(9), 0);
        check_eq("zero_used", tiles_used, 0);
        check_eq("zero_mism", count_mismatch, 1);
        ack("zero");

        // Reset during ACCUM after the first pop
        for (int k = 0; k < 3; k++) fill(k, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            act_load = 1'b1; activation_input = tiles[k]; num_input_tiles = 3'd3; mode = 1'b0;
        end
        @(negedge clk);
        act_load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("racc_ready", ready, 0);
        check_eq("racc_busy", busy, 0);
        check_eq("racc_lane0", lane(0), 0);
        check_eq("racc_used", tiles_used, 0);
        check_eq("racc_mism", count_mismatch, 0);
        reset = 1'b0;
        fill(0, 7);
        run_job("post", 1, 3'd1, 1'b0, 2);
        check_eq("post_lane0", lane(0), 7);
        check_eq("post_used", tiles_used, 1);
        check_eq("post_mism", count_mismatch, 0);
        ack("post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
